// File: rtl/dart_launcher.sv
// dart_launcher: unattended dart-throw generator for the dart game engine.
// Paces throws with an idle gap, draws board coordinates from a 16-bit LFSR,
// alternates players on the engine's turn-done handshake, tallies wins per
// player and raises a sticky error flag on protocol violations.
module dart_launcher #(
    parameter int unsigned DARTS_PER_TURN = 3,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned MAX_GAMES      = 8,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    input  logic       game_set_i,
    input  logic       player_1_done_i,
    input  logic       player_2_done_i,
    input  logic       player_1_win_i,
    input  logic       player_2_win_i,
    output logic       dart_come_o,
    output logic [3:0] dart_position_x_o,
    output logic [3:0] dart_position_y_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] games_o,
    output logic [7:0] p1_wins_o,
    output logic [7:0] p2_wins_o,
    output logic       err_o
);

    // An all-zero seed would lock the LFSR, so fall back to the default.
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
    localparam logic [3:0]  LAST_DART = 4'(DARTS_PER_TURN);
    localparam logic [7:0]  LAST_GAP  = 8'(GAP_CYCLES - 1);
    localparam logic [7:0]  GAME_LIMIT = 8'(MAX_GAMES);

    typedef enum logic [2:0] {
        IDLE, WAIT_SET, GAP, THROW, WAIT_DONE, FINISH
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  gap_cnt, gap_nxt;
    logic [3:0]  dart_cnt, dart_nxt;
    logic        player, player_nxt;
    logic [15:0] lfsr, lfsr_nxt;
    logic [7:0]  games_nxt, p1_nxt, p2_nxt;
    logic        err_nxt, come_nxt, busy_nxt, done_nxt;
    logic [3:0]  x_nxt, y_nxt;
    logic        win_any, win_both, cur_done, other_done, lfsr_fb;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Register all state and every output so nothing combinational leaves the block.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            gap_cnt           <= '0;
            dart_cnt          <= '0;
            player            <= 1'b0;
            lfsr              <= SEED;
            dart_come_o       <= 1'b0;
            dart_position_x_o <= '0;
            dart_position_y_o <= '0;
            busy_o            <= 1'b0;
            done_o            <= 1'b0;
            games_o           <= '0;
            p1_wins_o         <= '0;
            p2_wins_o         <= '0;
            err_o             <= 1'b0;
        end else begin
            state             <= state_nxt;
            gap_cnt           <= gap_nxt;
            dart_cnt          <= dart_nxt;
            player            <= player_nxt;
            lfsr              <= lfsr_nxt;
            dart_come_o       <= come_nxt;
            dart_position_x_o <= x_nxt;
            dart_position_y_o <= y_nxt;
            busy_o            <= busy_nxt;
            done_o            <= done_nxt;
            games_o           <= games_nxt;
            p1_wins_o         <= p1_nxt;
            p2_wins_o         <= p2_nxt;
            err_o             <= err_nxt;
        end
    end

    // Next-state logic; a win in an active state overrides whatever the state itself decided.
    always_comb begin
        state_nxt  = state;
        gap_nxt    = gap_cnt;
        dart_nxt   = dart_cnt;
        player_nxt = player;
        lfsr_nxt   = lfsr;
        games_nxt  = games_o;
        p1_nxt     = p1_wins_o;
        p2_nxt     = p2_wins_o;
        err_nxt    = err_o;
        x_nxt      = dart_position_x_o;
        y_nxt      = dart_position_y_o;

        win_any    = player_1_win_i | player_2_win_i;
        win_both   = player_1_win_i & player_2_win_i;
        cur_done   = player ? player_2_done_i : player_1_done_i;
        other_done = player ? player_1_done_i : player_2_done_i;
        lfsr_fb    = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

        case (state)
            IDLE, FINISH: begin
                if (start_i) begin
                    state_nxt  = WAIT_SET;
                    games_nxt  = '0;
                    p1_nxt     = '0;
                    p2_nxt     = '0;
                    err_nxt    = 1'b0;
                    player_nxt = 1'b0;
                    dart_nxt   = '0;
                end
                if (win_any) err_nxt = 1'b1;
            end
            WAIT_SET: begin
                if (win_any) err_nxt = 1'b1;
                if (game_set_i) begin
                    state_nxt  = GAP;
                    dart_nxt   = '0;
                    player_nxt = 1'b0;
                    gap_nxt    = '0;
                end
            end
            GAP: begin
                if (gap_cnt == LAST_GAP) begin
                    state_nxt = THROW;
                end else begin
                    gap_nxt = gap_cnt + 8'd1;
                end
            end
            THROW: begin
                lfsr_nxt = {lfsr_fb, lfsr[15:1]};
                dart_nxt = dart_cnt + 4'd1;
                gap_nxt  = '0;
                state_nxt = (dart_cnt + 4'd1 == LAST_DART) ? WAIT_DONE : GAP;
            end
            WAIT_DONE: begin
                if (cur_done) begin
                    player_nxt = ~player;
                    dart_nxt   = '0;
                    gap_nxt    = '0;
                    state_nxt  = GAP;
                end else if (other_done) begin
                    err_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if ((state == GAP || state == THROW || state == WAIT_DONE) && win_any) begin
            player_nxt = player;
            err_nxt    = err_o | win_both;
            games_nxt  = sat_inc(games_o);
            if (player_1_win_i) p1_nxt = sat_inc(p1_wins_o);
            if (player_2_win_i) p2_nxt = sat_inc(p2_wins_o);
            state_nxt  = (games_nxt == GAME_LIMIT) ? FINISH : WAIT_SET;
        end

        come_nxt = (state_nxt == THROW);
        if (come_nxt) begin
            x_nxt = lfsr[3:0];
            y_nxt = lfsr[7:4];
        end
        busy_nxt = (state_nxt != IDLE) && (state_nxt != FINISH);
        done_nxt = (state_nxt == FINISH);
    end

endmodule

// File: tb/tb_dart_launcher.sv
// Directed self-checking bench for dart_launcher (MAX_GAMES=2, other defaults).
module tb_dart_launcher;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start_i = 1'b0;
    logic       game_set_i = 1'b0;
    logic       player_1_done_i = 1'b0;
    logic       player_2_done_i = 1'b0;
    logic       player_1_win_i = 1'b0;
    logic       player_2_win_i = 1'b0;
    logic       dart_come_o;
    logic [3:0] dart_position_x_o;
    logic [3:0] dart_position_y_o;
    logic       busy_o;
    logic       done_o;
    logic [7:0] games_o;
    logic [7:0] p1_wins_o;
    logic [7:0] p2_wins_o;
    logic       err_o;

    int n_checks = 0;
    int n_fail   = 0;
    int n;
    int s;

    dart_launcher #(
        .DARTS_PER_TURN(3),
        .GAP_CYCLES(4),
        .MAX_GAMES(2),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start_i(start_i),
        .game_set_i(game_set_i),
        .player_1_done_i(player_1_done_i),
        .player_2_done_i(player_2_done_i),
        .player_1_win_i(player_1_win_i),
        .player_2_win_i(player_2_win_i),
        .dart_come_o(dart_come_o),
        .dart_position_x_o(dart_position_x_o),
        .dart_position_y_o(dart_position_y_o),
        .busy_o(busy_o),
        .done_o(done_o),
        .games_o(games_o),
        .p1_wins_o(p1_wins_o),
        .p2_wins_o(p2_wins_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance past k rising edges, landing 1ns after the last one.
    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Clock the currently driven pulse inputs once, drop them, then count edges
    // (including that first one) until a strobe appears; 40 means none arrived.
    task automatic count_to_strobe(output int edges);
        step(1);
        start_i = 0; game_set_i = 0;
        player_1_done_i = 0; player_2_done_i = 0;
        player_1_win_i = 0; player_2_win_i = 0;
        edges = 1;
        while (!dart_come_o && edges < 40) begin
            step(1);
            edges++;
        end
    endtask

    task automatic count_strobes(input int cycles, output int strobes);
        strobes = 0;
        repeat (cycles) begin
            step(1);
            if (dart_come_o) strobes++;
        end
    endtask

    initial begin
        // Reset state.
        #12;
        check("reset_come", 16'(dart_come_o), 16'h0);
        check("reset_busy", 16'(busy_o), 16'h0);
        check("reset_games", 16'(games_o), 16'h0);
        check("reset_err", 16'(err_o), 16'h0);
        reset = 1;
        step(2);

        // Start a run.
        start_i = 1;
        step(1);
        start_i = 0;
        check("start_busy", 16'(busy_o), 16'h1);
        check("start_done", 16'(done_o), 16'h0);

        // First turn: three strobes at x=1/y=E, x=0/y=7, x=8/y=3.
        game_set_i = 1;
        count_to_strobe(n);
        check("first_latency", 16'(n), 16'd5);
        check("first_xy", {8'h0, dart_position_y_o, dart_position_x_o}, 16'h00E1);
        count_to_strobe(n);
        check("second_spacing", 16'(n), 16'd5);
        check("second_xy", {8'h0, dart_position_y_o, dart_position_x_o}, 16'h0070);
        count_to_strobe(n);
        check("third_spacing", 16'(n), 16'd5);
        check("third_xy", {8'h0, dart_position_y_o, dart_position_x_o}, 16'h0038);
        count_strobes(20, s);
        check("no_fourth_strobe", 16'(s), 16'd0);
        check("xy_held", {8'h0, dart_position_y_o, dart_position_x_o}, 16'h0038);

        // Player 1 done -> player 2 gets three strobes.
        player_1_done_i = 1;
        count_to_strobe(n);
        check("p2_first_latency", 16'(n), 16'd5);
        check("p2_first_xy", {8'h0, dart_position_y_o, dart_position_x_o}, 16'h009C);
        count_to_strobe(n);
        check("p2_second_spacing", 16'(n), 16'd5);
        count_to_strobe(n);
        check("p2_third_spacing", 16'(n), 16'd5);
        check("err_before_wrong_done", 16'(err_o), 16'h0);

        // Wrong player's done during player 2's wait.
        step(2);
        player_1_done_i = 1;
        step(1);
        player_1_done_i = 0;
        check("wrong_done_err", 16'(err_o), 16'h1);
        count_strobes(20, s);
        check("wrong_done_no_strobe", 16'(s), 16'd0);

        // Win and done together: win taken, no further throw.
        player_2_win_i = 1;
        player_2_done_i = 1;
        step(1);
        player_2_win_i = 0;
        player_2_done_i = 0;
        check("wd_games", 16'(games_o), 16'd1);
        check("wd_p2_wins", 16'(p2_wins_o), 16'd1);
        check("wd_p1_wins", 16'(p1_wins_o), 16'd0);
        check("wd_busy", 16'(busy_o), 16'h1);
        count_strobes(20, s);
        check("wd_no_strobe", 16'(s), 16'd0);

        // Second game, player 1 wins during a gap -> run complete.
        game_set_i = 1;
        count_to_strobe(n);
        check("game2_latency", 16'(n), 16'd5);
        step(1);
        player_1_win_i = 1;
        step(1);
        player_1_win_i = 0;
        check("fin_games", 16'(games_o), 16'd2);
        check("fin_p1_wins", 16'(p1_wins_o), 16'd1);
        check("fin_p2_wins", 16'(p2_wins_o), 16'd1);
        check("fin_done", 16'(done_o), 16'h1);
        check("fin_busy", 16'(busy_o), 16'h0);
        count_strobes(10, s);
        check("fin_no_strobe", 16'(s), 16'd0);

        // Restart clears counters and error.
        start_i = 1;
        step(1);
        start_i = 0;
        check("restart_games", 16'(games_o), 16'd0);
        check("restart_p1", 16'(p1_wins_o), 16'd0);
        check("restart_p2", 16'(p2_wins_o), 16'd0);
        check("restart_err", 16'(err_o), 16'h0);
        check("restart_done", 16'(done_o), 16'h0);
        check("restart_busy", 16'(busy_o), 16'h1);

        // Both wins in the same cycle.
        game_set_i = 1;
        step(1);
        game_set_i = 0;
        step(1);
        player_1_win_i = 1;
        player_2_win_i = 1;
        step(1);
        player_1_win_i = 0;
        player_2_win_i = 0;
        check("both_p1", 16'(p1_wins_o), 16'd1);
        check("both_p2", 16'(p2_wins_o), 16'd1);
        check("both_games", 16'(games_o), 16'd1);
        check("both_err", 16'(err_o), 16'h1);
        check("both_busy", 16'(busy_o), 16'h1);

        // Asynchronous reset in the middle of a gap.
        game_set_i = 1;
        step(1);
        game_set_i = 0;
        step(2);
        reset = 0;
        #1;
        check("async_busy", 16'(busy_o), 16'h0);
        check("async_games", 16'(games_o), 16'd0);
        check("async_err", 16'(err_o), 16'h0);
        check("async_xy", {8'h0, dart_position_y_o, dart_position_x_o}, 16'h0000);
        step(2);
        reset = 1;
        step(1);
        start_i = 1;
        step(1);
        start_i = 0;
        game_set_i = 1;
        count_to_strobe(n);
        check("post_reset_latency", 16'(n), 16'd5);
        check("post_reset_xy", {8'h0, dart_position_y_o, dart_position_x_o}, 16'h00E1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
